// File: rtl/reshape_level_sequencer_pkg.sv
// Shared definitions for the level sequencer: width helpers, state encoding
// and the runtime active-level clamp.
package reshape_level_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } seq_state_t;

    // Level index width; a single-level build still needs one bit.
    function automatic int lvl_width(input int levels);
        return (levels <= 1) ? 1 : $clog2(levels);
    endfunction

    function automatic int cfg_width(input int levels);
        return $clog2(levels + 1);
    endfunction

    // Zero or an over-range request runs every synthesized level.
    function automatic int eff_levels(input int cfg, input int levels);
        return (cfg == 0 || cfg > levels) ? levels : cfg;
    endfunction

endpackage

// File: rtl/reshape_level_sequencer_reshape.sv
// Combinational bit-plane reshape: lane-interleaved word in, level-major planes out.
module reshape_level_sequencer_reshape #(
    parameter int BINARY_LEVELS = 2,
    parameter int SIMD_WIDTH    = 32
) (
    input  logic [SIMD_WIDTH*BINARY_LEVELS-1:0] i_data,
    output logic [SIMD_WIDTH*BINARY_LEVELS-1:0] o_planes
);

    // Input bit LEVELS*i+l (lane i, level l) lands at plane l, bit i.
    for (genvar l = 0; l < BINARY_LEVELS; l++) begin : g_level
        for (genvar i = 0; i < SIMD_WIDTH; i++) begin : g_lane
            assign o_planes[SIMD_WIDTH*l + i] = i_data[BINARY_LEVELS*i + l];
        end
    end

endmodule

// File: rtl/reshape_level_sequencer.sv
// Holds one reshaped activation word and emits one level plane per cycle
// under valid/ready backpressure, honouring a runtime active-level count.
module reshape_level_sequencer
    import reshape_level_sequencer_pkg::*;
#(
    parameter int BINARY_LEVELS = 2,
    parameter int SIMD_WIDTH    = 32,
    localparam int LW = lvl_width(BINARY_LEVELS),
    localparam int CW = cfg_width(BINARY_LEVELS)
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  logic [CW-1:0]                       cfg_levels,
    input  logic [SIMD_WIDTH*BINARY_LEVELS-1:0] in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [SIMD_WIDTH-1:0]               out_data,
    output logic [LW-1:0]                       out_level,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy
);

    seq_state_t                         r_state;
    logic [LW-1:0]                      r_lvl;
    logic [CW-1:0]                      r_nlev;
    logic [SIMD_WIDTH*BINARY_LEVELS-1:0] r_buf;

    logic [SIMD_WIDTH*BINARY_LEVELS-1:0] w_planes;
    logic [CW-1:0]                      w_eff_nlev;
    logic [LW-1:0]                      w_last_lvl;
    logic                               w_emit;
    logic                               w_accept;

    reshape_level_sequencer_reshape #(
        .BINARY_LEVELS (BINARY_LEVELS),
        .SIMD_WIDTH    (SIMD_WIDTH)
    ) u_reshape (
        .i_data   (in_data),
        .o_planes (w_planes)
    );

    assign w_eff_nlev = CW'(eff_levels(int'(cfg_levels), BINARY_LEVELS));
    // nlev never exceeds BINARY_LEVELS, so nlev-1 always fits the level index.
    assign w_last_lvl = LW'(r_nlev - CW'(1));
    assign w_emit     = (r_state == EMIT);

    assign out_valid  = w_emit;
    assign busy       = w_emit;
    assign out_level  = r_lvl;
    assign out_data   = r_buf[SIMD_WIDTH*int'(r_lvl) +: SIMD_WIDTH];
    assign out_last   = w_emit && (r_lvl == w_last_lvl);

    // A new word may enter in the same cycle the last plane leaves.
    assign in_ready   = !w_emit || (out_ready && out_last);
    assign w_accept   = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
            r_lvl   <= '0;
            r_nlev  <= CW'(BINARY_LEVELS);
            r_buf   <= '0;
        end else if (w_accept) begin
            r_state <= EMIT;
            r_lvl   <= '0;
            r_nlev  <= w_eff_nlev;
            r_buf   <= w_planes;
        end else if (w_emit && out_ready) begin
            if (out_last) begin
                r_state <= IDLE;
            end else begin
                r_lvl <= r_lvl + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reshape_level_sequencer.sv
// Directed bench for reshape_level_sequencer with LEVELS=2, SIMD=4.
module tb_reshape_level_sequencer;

    localparam int LEVELS = 2;
    localparam int SIMD   = 4;

    logic                   clk;
    logic                   rst_n;
    logic [1:0]             cfg_levels;
    logic [SIMD*LEVELS-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [SIMD-1:0]        out_data;
    logic [0:0]             out_level;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    int n_total  = 0;
    int n_bad    = 0;
    int n_planes = 0;

    reshape_level_sequencer #(
        .BINARY_LEVELS (LEVELS),
        .SIMD_WIDTH    (SIMD)
    ) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .cfg_levels (cfg_levels),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_level  (out_level),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Count accepted planes, then advance to the next negedge.
    task automatic step();
        #1;
        if (out_valid && out_ready) n_planes++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_plane(input string tag, input logic [3:0] d, input logic l, input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".level"}, 32'(out_level), 32'(l));
        check({tag, ".last"},  32'(out_last),  32'(last));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"},  32'(busy),      32'd0);
        check({tag, ".rdy"},   32'(in_ready),  32'd1);
    endtask

    task automatic offer(input logic [7:0] d, input logic [1:0] cfg);
        in_data    = d;
        cfg_levels = cfg;
        in_valid   = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_levels = 2'd2;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Reset state
        check_idle("rst");
        check("rst.last",  32'(out_last),  32'd0);
        check("rst.level", 32'(out_level), 32'd0);
        check("rst.data",  32'(out_data),  32'd0);

        // Single word B4, two levels
        offer(8'hB4, 2'd2);
        #1 check("t1.rdy0", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1 check_plane("t1.p0", 4'h6, 1'b0, 1'b0);
        check("t1.rdy1", 32'(in_ready), 32'd0);
        step();
        check_plane("t1.p1", 4'hC, 1'b1, 1'b1);
        check("t1.rdy2", 32'(in_ready), 32'd1);
        step();
        check_idle("t1.end");

        // Back-to-back B4 then FF with in_valid held
        offer(8'hB4, 2'd2);
        #1 check("t2.rdy0", 32'(in_ready), 32'd1);
        step();
        offer(8'hFF, 2'd2);
        #1 check_plane("t2.p0", 4'h6, 1'b0, 1'b0);
        check("t2.rdy1", 32'(in_ready), 32'd0);
        step();
        check_plane("t2.p1", 4'hC, 1'b1, 1'b1);
        check("t2.rdy2", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1 check_plane("t2.p2", 4'hF, 1'b0, 1'b0);
        check("t2.rdy3", 32'(in_ready), 32'd0);
        step();
        check_plane("t2.p3", 4'hF, 1'b1, 1'b1);
        step();
        check_idle("t2.end");

        // Backpressure: out_ready toggled every cycle
        offer(8'hB4, 2'd2);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1 check_plane("t3.s0", 4'h6, 1'b0, 1'b0);
        check("t3.rdy0", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b1;
        #1 check_plane("t3.h0", 4'h6, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        #1 check_plane("t3.s1", 4'hC, 1'b1, 1'b1);
        check("t3.rdy1", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b1;
        #1 check_plane("t3.h1", 4'hC, 1'b1, 1'b1);
        check("t3.rdy2", 32'(in_ready), 32'd1);
        step();
        check_idle("t3.end");

        // cfg=1 gives one plane; cfg=0 clamps to two
        offer(8'hB4, 2'd1);
        step();
        offer(8'hB4, 2'd0);
        #1 check_plane("t4.w0", 4'h6, 1'b0, 1'b1);
        check("t4.rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1 check_plane("t4.w1p0", 4'h6, 1'b0, 1'b0);
        step();
        check_plane("t4.w1p1", 4'hC, 1'b1, 1'b1);
        step();
        check_idle("t4.end");

        // cfg change during EMIT affects only the next word
        offer(8'hB4, 2'd2);
        step();
        in_valid   = 1'b0;
        cfg_levels = 2'd1;
        #1 check_plane("t5.p0", 4'h6, 1'b0, 1'b0);
        step();
        offer(8'hFF, 2'd1);
        #1 check_plane("t5.p1", 4'hC, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        #1 check_plane("t5.w1", 4'hF, 1'b0, 1'b1);
        step();
        check_idle("t5.end");

        // Reset asserted after level 0 leaves
        offer(8'hB4, 2'd2);
        step();
        in_valid = 1'b0;
        #1 check_plane("t6.p0", 4'h6, 1'b0, 1'b0);
        step();
        check_plane("t6.p1", 4'hC, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1 check("t6.rst.valid", 32'(out_valid), 32'd0);
        check("t6.rst.busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        #1 check_idle("t6.rel0");
        step();
        check_idle("t6.rel1");
        step();

        check("planes", 32'(n_planes), 32'd15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
